// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank: default parameters and the
// per-channel request encoding used by every counter cell.
package counter_bank_pkg;

    localparam int DEF_CH      = 2;
    localparam int DEF_W       = 4;
    localparam int DEF_EN_DLY  = 3;
    localparam int DEF_CASCADE = 0;

    typedef enum logic [1:0] {
        REQ_HOLD = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_INC  = 2'd2,
        REQ_DEC  = 2'd3
    } req_e;

    // Load wins; inc and dec together cancel to a hold.
    function automatic req_e encode_req(input logic load, input logic inc, input logic dec);
        if (load)
            return REQ_LOAD;
        else if (inc && !dec)
            return REQ_INC;
        else if (dec && !inc)
            return REQ_DEC;
        return REQ_HOLD;
    endfunction

endpackage

// File: rtl/counter_bank_counter_cell.sv
// One W-bit up/down counter channel with parallel load, wrap/saturate
// selection, combinational wrap flags and registered carry/borrow pulses.
module counter_cell
    import counter_bank_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ready,
    input  logic         sat_mode,
    input  logic         load,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] din,
    output logic [W-1:0] count,
    output logic         wrap_up,
    output logic         wrap_dn,
    output logic         carry,
    output logic         borrow
);

    localparam logic [W-1:0] MAX = '1;

    req_e req;

    function automatic logic [W-1:0] next_count(input req_e r, input logic [W-1:0] c,
                                                 input logic [W-1:0] d, input logic sat);
        case (r)
            REQ_LOAD: return d;
            REQ_INC:  return (sat && c == MAX) ? c : c + W'(1);
            REQ_DEC:  return (sat && c == '0) ? c : c - W'(1);
            default:  return c;
        endcase
    endfunction

    assign req     = ready ? encode_req(load, inc, dec) : REQ_HOLD;
    // The wrap flags also feed the next channel's ripple in cascade mode.
    assign wrap_up = (req == REQ_INC) && !sat_mode && (count == MAX);
    assign wrap_dn = (req == REQ_DEC) && !sat_mode && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            count  <= next_count(req, count, din, sat_mode);
            carry  <= wrap_up;
            borrow <= wrap_dn;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of CH up/down counters with a start-up enable delay and an optional
// cascade that chains the channels into one CH*W-bit counter.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int CH      = DEF_CH,
    parameter int W       = DEF_W,
    parameter int EN_DLY  = DEF_EN_DLY,
    parameter int CASCADE = DEF_CASCADE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0]   load_en,
    input  logic [CH*W-1:0] din,
    input  logic [CH-1:0]   inc_en,
    input  logic [CH-1:0]   dec_en,
    input  logic [CH-1:0]   sat_mode,
    output logic          ready,
    output logic [CH*W-1:0] dout,
    output logic [CH-1:0]   carry,
    output logic [CH-1:0]   borrow
);

    logic [EN_DLY-1:0] dly;
    logic              unused_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dly <= '0;
        else
            dly <= (dly << 1) | EN_DLY'(1);
    end

    assign ready = dly[EN_DLY-1];

    // Upper channels' own inc/dec are ignored when cascaded.
    assign unused_req = ^{inc_en, dec_en};

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic inc_eff, dec_eff, wu, wd;

        if (CASCADE != 0 && i > 0) begin : g_casc
            assign inc_eff = g_ch[i-1].wu;
            assign dec_eff = g_ch[i-1].wd;
        end else begin : g_own
            assign inc_eff = inc_en[i];
            assign dec_eff = dec_en[i];
        end

        counter_cell #(.W(W)) u_cell (
            .clk      (clk),
            .reset    (reset),
            .ready    (ready),
            .sat_mode (sat_mode[i]),
            .load     (load_en[i]),
            .inc      (inc_eff),
            .dec      (dec_eff),
            .din      (din[i*W +: W]),
            .count    (dout[i*W +: W]),
            .wrap_up  (wu),
            .wrap_dn  (wd),
            .carry    (carry[i]),
            .borrow   (borrow[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: an independent bank (A) and a
// cascaded bank (B), with table vectors, hand sequences and random stimulus.
module tb_counter_bank;

    localparam int CH     = 2;
    localparam int W      = 4;
    localparam int EN_DLY = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] a_load, a_inc, a_dec, a_sat, a_carry, a_borrow;
    logic [7:0] a_din, a_dout;
    logic       a_ready;
    logic [1:0] b_load, b_inc, b_dec, b_sat, b_carry, b_borrow;
    logic [7:0] b_din, b_dout;
    logic       b_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         ma [CH];
    logic [1:0] ma_c, ma_b;
    int         mb;
    logic [1:0] mb_c, mb_b;
    int         since_rel;
    logic       m_ready;

    typedef struct {
        logic [1:0] load, inc, dec, sat;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic [1:0] exp_carry, exp_borrow;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    counter_bank #(.CH(CH), .W(W), .EN_DLY(EN_DLY), .CASCADE(0)) dut_a (
        .clk(clk), .reset(reset), .load_en(a_load), .din(a_din), .inc_en(a_inc),
        .dec_en(a_dec), .sat_mode(a_sat), .ready(a_ready), .dout(a_dout),
        .carry(a_carry), .borrow(a_borrow)
    );

    counter_bank #(.CH(CH), .W(W), .EN_DLY(EN_DLY), .CASCADE(1)) dut_b (
        .clk(clk), .reset(reset), .load_en(b_load), .din(b_din), .inc_en(b_inc),
        .dec_en(b_dec), .sat_mode(b_sat), .ready(b_ready), .dout(b_dout),
        .carry(b_carry), .borrow(b_borrow)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pack_a();
        return ma[1] * 16 + ma[0];
    endfunction

    task automatic model_reset();
        ma[0] = 0; ma[1] = 0; ma_c = '0; ma_b = '0;
        mb = 0; mb_c = '0; mb_b = '0;
        since_rel = 0; m_ready = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic rdy;
        int   mask;
        rdy  = (since_rel >= EN_DLY);
        ma_c = '0; ma_b = '0; mb_c = '0; mb_b = '0;
        if (rdy) begin
            for (int i = 0; i < CH; i++) begin
                if (a_load[i])
                    ma[i] = int'(a_din[i*4 +: 4]);
                else if (a_inc[i] && !a_dec[i]) begin
                    if (ma[i] == 15) begin
                        if (!a_sat[i]) begin ma[i] = 0; ma_c[i] = 1'b1; end
                    end else ma[i]++;
                end else if (a_dec[i] && !a_inc[i]) begin
                    if (ma[i] == 0) begin
                        if (!a_sat[i]) begin ma[i] = 15; ma_b[i] = 1'b1; end
                    end else ma[i]--;
                end
            end
            if (b_load == 2'b11)
                mb = int'(b_din);
            else if (b_load == 2'b00 && (b_inc[0] ^ b_dec[0])) begin
                for (int i = 0; i < CH; i++) begin
                    mask = (1 << ((i + 1) * 4)) - 1;
                    if (b_inc[0] && (mb & mask) == mask) mb_c[i] = 1'b1;
                    if (b_dec[0] && (mb & mask) == 0)    mb_b[i] = 1'b1;
                end
                mb = b_inc[0] ? ((mb + 1) & 255) : ((mb + 255) & 255);
            end
        end
        since_rel++;
        m_ready = (since_rel >= EN_DLY);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        a_load = '0; a_inc = '0; a_dec = '0; a_sat = '0; a_din = '0;
        b_load = '0; b_inc = '0; b_dec = '0; b_sat = '0; b_din = '0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        chk("reset_dout", int'(a_dout), 0);
        chk("reset_ready", int'(a_ready), 0);
        chk("reset_carry", int'(a_carry), 0);

        // Start-up delay with increments requested throughout
        a_inc = 2'b11;
        @(negedge clk) reset = 1'b0;
        for (int k = 1; k <= EN_DLY; k++) begin
            tick();
            chk($sformatf("startup_dout_e%0d", k), int'(a_dout), 0);
            chk($sformatf("startup_ready_e%0d", k), int'(a_ready), (k == EN_DLY) ? 1 : 0);
        end
        tick();
        chk("startup_first_count", int'(a_dout), 8'h11);
        tick();
        chk("startup_second_count", int'(a_dout), 8'h22);
        a_inc = '0;

        // Wrap/saturate/priority vectors on the independent bank (ch0 wrap, ch1 sat)
        tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b10, 8'hEE, 8'hEE, 2'b00, 2'b00};
        tbl[1]  = '{2'b00, 2'b11, 2'b00, 2'b10, 8'h00, 8'hFF, 2'b00, 2'b00};
        tbl[2]  = '{2'b00, 2'b11, 2'b00, 2'b10, 8'h00, 8'hF0, 2'b01, 2'b00};
        tbl[3]  = '{2'b00, 2'b11, 2'b00, 2'b10, 8'h00, 8'hF1, 2'b00, 2'b00};
        tbl[4]  = '{2'b11, 2'b00, 2'b00, 2'b10, 8'h11, 8'h11, 2'b00, 2'b00};
        tbl[5]  = '{2'b00, 2'b00, 2'b11, 2'b10, 8'h00, 8'h00, 2'b00, 2'b00};
        tbl[6]  = '{2'b00, 2'b00, 2'b11, 2'b10, 8'h00, 8'h0F, 2'b00, 2'b01};
        tbl[7]  = '{2'b00, 2'b00, 2'b11, 2'b10, 8'h00, 8'h0E, 2'b00, 2'b00};
        tbl[8]  = '{2'b01, 2'b01, 2'b00, 2'b10, 8'h09, 8'h09, 2'b00, 2'b00};
        tbl[9]  = '{2'b00, 2'b11, 2'b11, 2'b10, 8'h00, 8'h09, 2'b00, 2'b00};
        tbl[10] = '{2'b00, 2'b10, 2'b00, 2'b10, 8'h00, 8'h19, 2'b00, 2'b00};
        for (int v = 0; v < 11; v++) begin
            a_load = tbl[v].load; a_inc = tbl[v].inc; a_dec = tbl[v].dec;
            a_sat = tbl[v].sat; a_din = tbl[v].din;
            tick();
            chk($sformatf("vec%0d_dout", v), int'(a_dout), int'(tbl[v].exp_dout));
            chk($sformatf("vec%0d_carry", v), int'(a_carry), int'(tbl[v].exp_carry));
            chk($sformatf("vec%0d_borrow", v), int'(a_borrow), int'(tbl[v].exp_borrow));
        end
        a_load = '0; a_inc = '0; a_dec = '0; a_sat = '0;

        // Cascade sequences
        b_load = 2'b11; b_din = 8'h0F; tick();
        chk("casc_load", int'(b_dout), 8'h0F);
        b_load = 2'b00; b_inc = 2'b01; tick();
        chk("casc_inc_dout", int'(b_dout), 8'h10);
        chk("casc_inc_carry", int'(b_carry), 2'b01);
        b_inc = 2'b00; b_load = 2'b11; b_din = 8'h00; tick();
        b_load = 2'b00; b_dec = 2'b01; tick();
        chk("casc_dec_dout", int'(b_dout), 8'hFF);
        chk("casc_dec_borrow", int'(b_borrow), 2'b11);
        b_dec = 2'b00; b_load = 2'b11; b_din = 8'h0F; tick();
        b_load = 2'b10; b_din = 8'h50; b_inc = 2'b01; tick();
        chk("casc_load_override", int'(b_dout), 8'h50);
        chk("casc_override_carry", int'(b_carry), 2'b01);
        b_load = 2'b00; b_inc = 2'b10; tick();
        chk("casc_own_inc_ignored", int'(b_dout), 8'h50);
        b_load = 2'b11; b_din = 8'h0F; b_inc = 2'b00; tick();
        b_load = 2'b00; b_sat = 2'b01; b_inc = 2'b01; tick();
        chk("casc_sat_no_ripple", int'(b_dout), 8'h0F);
        chk("casc_sat_no_carry", int'(b_carry), 0);
        b_sat = 2'b00; b_inc = 2'b00;

        // Randomized stimulus against the model
        for (int n = 0; n < 300; n++) begin
            a_load = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            a_inc  = 2'($urandom);
            a_dec  = 2'($urandom);
            a_sat  = 2'($urandom);
            a_din  = 8'($urandom);
            b_load = (n == 0 || $urandom_range(0, 15) == 0) ? 2'b11 : 2'b00;
            b_inc  = 2'($urandom);
            b_dec  = 2'($urandom);
            b_din  = 8'($urandom);
            tick();
            chk("rand_a_dout", int'(a_dout), pack_a());
            chk("rand_a_carry", int'(a_carry), int'(ma_c));
            chk("rand_a_borrow", int'(a_borrow), int'(ma_b));
            chk("rand_b_dout", int'(b_dout), mb);
            chk("rand_b_carry", int'(b_carry), int'(mb_c));
            chk("rand_b_borrow", int'(b_borrow), int'(mb_b));
        end

        // Mid-operation asynchronous reset
        a_load = 2'b11; a_din = 8'h77; a_inc = 2'b00; a_dec = 2'b00; a_sat = 2'b00;
        b_load = 2'b00; b_inc = 2'b00; b_dec = 2'b00;
        tick();
        a_load = 2'b00; a_inc = 2'b11; tick();
        chk("midreset_pre", int'(a_dout), 8'h88);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("midreset_dout", int'(a_dout), 0);
        chk("midreset_ready", int'(a_ready), 0);
        @(negedge clk) reset = 1'b0;
        for (int k = 1; k <= EN_DLY; k++) begin
            tick();
            chk($sformatf("restart_dout_e%0d", k), int'(a_dout), 0);
            chk($sformatf("restart_ready_e%0d", k), int'(a_ready), int'(m_ready));
        end
        tick();
        chk("restart_count", int'(a_dout), 8'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of CH synchronous up/down counters, each W bits wide, with parallel load, per-channel wrap/saturate mode and registered carry/borrow pulses. An optional cascade mode chains the channels into one CH*W-bit counter. A built-in start-up delay holds all channels idle for EN_DLY clocks after asynchronous reset release. This is the generalised replacement for the fixed two-nibble up/down counter pair and sits directly below the top-level core.

## Interface
Parameters:
- CH, 2, number of channels (≥1)
- W, 4, bits per channel (≥2)
- EN_DLY, 3, clocks after reset release before counting is enabled (≥1)
- CASCADE, 0, 1 = channel i>0 counts on channel i-1 carry/borrow (LSB is channel 0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- load_en  in  CH  per-channel parallel load request
- din  in  CH*W  load values, channel i at [i*W+W-1 : i*W]
- inc_en  in  CH  per-channel increment request
- dec_en  in  CH  per-channel decrement request
- sat_mode  in  CH  1 = saturate at limits, 0 = wrap
- ready  out  1  high once the start-up delay has elapsed
- dout  out  CH*W  counter values, same packing as din
- carry  out  CH  one-cycle pulse, channel wrapped max→0
- borrow  out  CH  one-cycle pulse, channel wrapped 0→max

## Operation
- Start-up: an EN_DLY-deep shift register fills with 1s after reset release; ready = last stage. While ready=0, all load/inc/dec requests are ignored.
- Per-channel priority when ready=1: load_en > (inc XOR dec) > hold.
  - inc and dec together means hold.
  - Load has no carry/borrow side effect.
- Wrap mode:
  - Increment at 2^W-1 gives 0 and pulses carry.
  - Decrement at 0 gives 2^W-1 and pulses borrow.
- Saturate mode:
  - Increment at 2^W-1 and decrement at 0 hold the value.
  - No carry or borrow pulse.
- CASCADE=1:
  - Channel 0 uses its own inc_en/dec_en.
  - For i>0, inc_eff[i] = channel i-1 wrapping up in this same cycle (combinational ripple), and dec_eff[i] = channel i-1 wrapping down.
  - Own inc_en/dec_en[i>0] are ignored; load_en[i] still works and takes priority.
  - A load on channel i-1 suppresses the cascade into channel i.
  - sat_mode applies per channel. A saturated channel never wraps, so it never cascades.
- CASCADE=0: channels are fully independent.

## Timing
- Reset (async assert) sets dout=0, carry=0, borrow=0, ready=0 and clears the shift register immediately.
- ready rises on the EN_DLY-th rising clk edge after reset deasserts.
- Latency is 1 cycle: requests sampled at edge k are visible on dout after edge k.
- carry/borrow are registered and high for exactly the cycle in which dout shows the wrapped value.
- In cascade mode, a full-chain ripple completes in one cycle: all affected channels update on the same edge.
- Reset asserted mid-count aborts immediately. After release, counting waits EN_DLY edges again.
- Requests held high continuously count once per clock.

## Structure
- Shared package holds the request-encoding constants (LOAD/INC/DEC/HOLD) and the default parameter values.
- One sub-module, counter_cell: a single W-bit channel with load/inc/dec/sat inputs, count output, wrap_up/wrap_dn combinational flags and registered carry/borrow.
- counter_bank contains the enable shift register, a generate loop over CH cells and the cascade muxing.

## Test plan
- Start-up delay: release reset with inc_en=all 1s, EN_DLY=3 → dout stays 0 for 3 edges, ready rises on edge 3, channel counts 1,2,… from the next edge.
- Wrap and saturate (W=4, ch0 wrap, ch1 sat, both inc from 14) → ch0: 15, 0 (carry high that cycle), 1. ch1: 15, 15, 15, carry never high. Same check downward from 1 for borrow.
- Priority: load_en=1, inc_en=1, din=0x9 → dout=0x9 and no pulse. Then inc=dec=1 → dout holds 0x9.
- Cascade (CH=2, W=4, CASCADE=1): load 0x0F as the 8-bit value, inc ch0 → 0x10 in one edge with carry[0]=1. Decrement from 0x00 → 0xFF with borrow[0]=1 and borrow[1]=1.
- Cascade load override: ch0 at 0xF incrementing while load_en[1]=1 with din=0x5 → result 0x50.
- Mid-operation reset: counting at 0x7, assert reset asynchronously between edges → dout=0 and ready=0 immediately. After release, full start-up delay applies again.
